// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with prescaled ticks, one-cycle done pulse,
// and either a latched expired state or automatic reload at zero.
module countdown_timer #(
  parameter int WIDTH       = 4,
  parameter int PRESCALE    = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] data,
  output logic             running,
  output logic             done,
  output logic             expired
);
  localparam int PW = $clog2(PRESCALE) + 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, reload_q, reload_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             done_q, done_d;
  logic             tick, term;
  assign tick = state_q == RUN && enable && pre_q == PW'(PRESCALE - 1);
  assign term = tick && data_q == WIDTH'(1);
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    pre_d    = pre_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      data_d   = load_value;
      reload_d = load_value;
      pre_d    = '0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = (enable && data_q != '0) ? RUN : IDLE;
        RUN: begin
          state_d = !enable ? PAUSE : (term && !AUTO_RELOAD) ? EXPIRED : RUN;
          pre_d   = !enable ? pre_q : tick ? '0 : pre_q + 1'b1;
          data_d  = !tick ? data_q : term ? (AUTO_RELOAD ? reload_q : '0) : data_q - 1'b1;
          done_d  = term;
        end
        PAUSE: state_d = enable ? RUN : PAUSE;
        default: data_d = '0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      done_q   <= done_d;
    end
  end
  assign data    = data_q;
  assign running = state_q == RUN;
  assign expired = state_q == EXPIRED;
  assign done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: three timer variants driven in parallel, checked against an
// elapsed-time reference model through a scoreboard queue.
module tb_countdown_timer;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst, enable, load;
  logic [3:0] load_value;
  logic [N-1:0][3:0] dq;
  logic [N-1:0] runq, dnq, exq;
  int vectors = 0;
  int miscompares = 0;
  typedef struct packed {
    logic [N-1:0][3:0] d;
    logic [N-1:0] run, dn, ex;
  } exp_t;
  exp_t sb[$];
  int st[N];
  int lval[N];
  int elapsed[N];
  always #5 clk = ~clk;
  countdown_timer #(.WIDTH(4), .PRESCALE(4), .AUTO_RELOAD(1'b0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
    .data(dq[0]), .running(runq[0]), .done(dnq[0]), .expired(exq[0]));
  countdown_timer #(.WIDTH(4), .PRESCALE(4), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
    .data(dq[1]), .running(runq[1]), .done(dnq[1]), .expired(exq[1]));
  countdown_timer #(.WIDTH(4), .PRESCALE(1), .AUTO_RELOAD(1'b0)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
    .data(dq[2]), .running(runq[2]), .done(dnq[2]), .expired(exq[2]));
  function automatic int ps(int k);
    return (k == 2) ? 1 : 4;
  endfunction
  function automatic bit ar(int k);
    return k == 1;
  endfunction
  // model: state 0 idle, 1 run, 2 pause, 3 expired; count = loaded - advancing run edges / prescale
  task automatic cycle(input logic r_i, input logic ld, input logic [3:0] v, input logic en);
    exp_t e;
    rst = r_i;
    load = ld;
    load_value = v;
    enable = en;
    e = '0;
    for (int k = 0; k < N; k++) begin
      if (r_i) begin
        st[k] = 0; lval[k] = 0; elapsed[k] = 0;
      end else if (ld) begin
        st[k] = 0; lval[k] = int'(v); elapsed[k] = 0;
      end else if (st[k] == 0) begin
        if (en && lval[k] != 0) st[k] = 1;
      end else if (st[k] == 1) begin
        if (!en) st[k] = 2;
        else begin
          elapsed[k]++;
          if (elapsed[k] == lval[k] * ps(k)) begin
            e.dn[k] = 1'b1;
            elapsed[k] = 0;
            if (!ar(k)) st[k] = 3;
          end
        end
      end else if (st[k] == 2) begin
        if (en) st[k] = 1;
      end
      e.d[k]   = (st[k] == 3) ? 4'd0 : 4'(lval[k] - elapsed[k] / ps(k));
      e.run[k] = st[k] == 1;
      e.ex[k]  = st[k] == 3;
    end
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < N; k++) begin
          vectors++;
          if ({dq[k], runq[k], dnq[k], exq[k]} !== {e.d[k], e.run[k], e.dn[k], e.ex[k]}) begin
            miscompares++;
            $display("FAIL outputs inst%0d t=%0t got d=%0d run=%b done=%b exp=%b want d=%0d run=%b done=%b exp=%b",
                     k, $time, dq[k], runq[k], dnq[k], exq[k], e.d[k], e.run[k], e.dn[k], e.ex[k]);
          end
        end
      end
    end
  end
  initial begin
    int hit;
    repeat (3) cycle(1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd5, 1'b0);
    hit = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 1'b1);
      if (dnq[0]) begin
        hit = i;
        break;
      end
    end
    vectors++;
    if (hit != 21) begin
      miscompares++;
      $display("FAIL done_latency got edge %0d want edge 21", hit);
    end
    repeat (3) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd3, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (22) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 30 && dq[0] != 4'd2; i++) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd9, 1'b1);
    repeat (40) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd6, 1'b1);
    cycle(1'b0, 1'b1, 4'd1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 1'b1, 4'd1, 1'b1);
    cycle(1'b0, 1'b1, 4'd2, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    cycle(1'b1, 1'b1, 4'd7, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(63) == 0), 1'($urandom_range(9) == 0),
            4'($urandom_range(15)), 1'($urandom_range(3) != 0));
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
